// File: rtl/bcd_cnt_pkg.sv
// Shared decade constants, digit type and load clamp for the BCD event counter.
package bcd_cnt_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BCD_MAX = 9;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   // Any non-BCD nibble is forced to nine so a decade never holds an illegal code.
   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t v);
      return (v > DIGIT_W'(BCD_MAX)) ? DIGIT_W'(BCD_MAX) : v;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear, clamped load, and +1/-1 step with ripple carry/borrow out.
module bcd_digit
   import bcd_cnt_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   input  logic               carry_in,
   input  logic               borrow_in,
   output logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] digit_next,
   output logic               carry_out,
   output logic               borrow_out
);

   localparam bcd_digit_t MAX_D = DIGIT_W'(BCD_MAX);

   bcd_digit_t digit_q;
   bcd_digit_t digit_d;

   // Carry/borrow ripple combinationally so a full-length ripple lands in one edge.
   assign carry_out  = carry_in  & (digit_q == MAX_D);
   assign borrow_out = borrow_in & (digit_q == '0);

   always_comb begin
      digit_d = digit_q;
      if (clear) begin
         digit_d = '0;
      end else if (load) begin
         digit_d = bcd_clamp(load_val);
      end else if (carry_in) begin
         digit_d = (digit_q == MAX_D) ? '0 : DIGIT_W'(digit_q + DIGIT_W'(1));
      end else if (borrow_in) begin
         digit_d = (digit_q == '0) ? MAX_D : DIGIT_W'(digit_q - DIGIT_W'(1));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit      = digit_q;
   assign digit_next = digit_d;

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-decade BCD up/down event counter with optional input synchronizers.
// Define BCD_CNT_SATURATE_EN to hold at all nines with a sticky overflow flag.
module bcd_event_counter
   import bcd_cnt_pkg::*;
#(
   parameter int unsigned NDIGITS     = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       load,
   input  logic [DIGIT_W*NDIGITS-1:0] load_val,
   input  logic                       inc,
   input  logic                       dec,
   output logic [DIGIT_W*NDIGITS-1:0] digits,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       zero
);

   localparam int unsigned W = DIGIT_W * NDIGITS;

   logic         inc_evt;
   logic         dec_evt;
   logic         inc_only;
   logic         dec_only;
   logic         ctl;
   logic [W-1:0] digits_q;
   logic [W-1:0] digits_d;
   logic [NDIGITS:0] carry;
   logic [NDIGITS:0] borrow;
   logic         overflow_q;
   logic         underflow_q;
   logic         zero_q;

   // Event front end: synchronize, then register a one-cycle pulse per rising edge.
   if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] inc_sync_q;
      logic [SYNC_STAGES-1:0] dec_sync_q;
      logic                   inc_prev_q;
      logic                   dec_prev_q;
      logic                   inc_evt_q;
      logic                   dec_evt_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            inc_sync_q <= '0;
            dec_sync_q <= '0;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
            inc_evt_q  <= 1'b0;
            dec_evt_q  <= 1'b0;
         end else begin
            inc_sync_q[0] <= inc;
            dec_sync_q[0] <= dec;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
               inc_sync_q[i] <= inc_sync_q[i-1];
               dec_sync_q[i] <= dec_sync_q[i-1];
            end
            inc_prev_q <= inc_sync_q[SYNC_STAGES-1];
            dec_prev_q <= dec_sync_q[SYNC_STAGES-1];
            inc_evt_q  <= inc_sync_q[SYNC_STAGES-1] & ~inc_prev_q;
            dec_evt_q  <= dec_sync_q[SYNC_STAGES-1] & ~dec_prev_q;
         end
      end

      assign inc_evt = inc_evt_q;
      assign dec_evt = dec_evt_q;
   end else begin : g_direct
      assign inc_evt = inc;
      assign dec_evt = dec;
   end

   // Opposing events cancel; clear/load override any event.
   assign inc_only = inc_evt & ~dec_evt;
   assign dec_only = dec_evt & ~inc_evt;
   assign ctl      = clear | load;

   logic all_nines;
   always_comb begin
      all_nines = 1'b1;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         if (digits_q[i*DIGIT_W +: DIGIT_W] != DIGIT_W'(BCD_MAX)) all_nines = 1'b0;
      end
   end

`ifdef BCD_CNT_SATURATE_EN
   logic sat_hold;
   assign sat_hold  = inc_only & all_nines;
   assign carry[0]  = inc_only & ~sat_hold;
`else
   assign carry[0]  = inc_only;
`endif
   assign borrow[0] = dec_only;

   for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk        (clk),
         .reset      (reset),
         .clear      (clear),
         .load       (load),
         .load_val   (load_val[g*DIGIT_W +: DIGIT_W]),
         .carry_in   (carry[g]),
         .borrow_in  (borrow[g]),
         .digit      (digits_q[g*DIGIT_W +: DIGIT_W]),
         .digit_next (digits_d[g*DIGIT_W +: DIGIT_W]),
         .carry_out  (carry[g+1]),
         .borrow_out (borrow[g+1])
      );
   end

   // Flags are computed from the same step that updates the digits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         zero_q      <= (digits_d == '0);
         underflow_q <= ~ctl & borrow[NDIGITS];
`ifdef BCD_CNT_SATURATE_EN
         overflow_q  <= ctl ? 1'b0 : (overflow_q | sat_hold | carry[NDIGITS]);
`else
         overflow_q  <= ~ctl & carry[NDIGITS];
`endif
      end
   end

   assign digits    = digits_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Directed self-checking bench for bcd_event_counter (NDIGITS=4, SYNC_STAGES=2).
module tb_bcd_event_counter;

   logic        clk;
   logic        reset;
   logic        clear;
   logic        load;
   logic [15:0] load_val;
   logic        inc;
   logic        dec;
   logic [15:0] digits;
   logic        overflow;
   logic        underflow;
   logic        zero;

   int n_tests;
   int n_failed;

   bcd_event_counter #(.NDIGITS(4), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .load      (load),
      .load_val  (load_val),
      .inc       (inc),
      .dec       (dec),
      .digits    (digits),
      .overflow  (overflow),
      .underflow (underflow),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Inputs change on the falling edge; pulse stays high for one cycle.
   task automatic pulse(input logic up, input logic down);
      inc = up;
      dec = down;
      cyc(1);
      inc = 1'b0;
      dec = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v);
      load     = 1'b1;
      load_val = v;
      cyc(1);
      load     = 1'b0;
   endtask

   initial begin
      n_tests  = 0;
      n_failed = 0;
      reset    = 1'b1;
      clear    = 1'b0;
      load     = 1'b0;
      load_val = 16'h0000;
      inc      = 1'b0;
      dec      = 1'b0;

      #3;
      check("rst_digits", 32'(digits), 32'h0000);
      check("rst_zero", 32'(zero), 32'h1);
      check("rst_ovf", 32'(overflow), 32'h0);
      check("rst_unf", 32'(underflow), 32'h0);
      cyc(2);
      reset = 1'b0;
      cyc(1);

      // Ten increments -> 0x0010, with the pipeline latency checked on the last.
      for (int i = 0; i < 10; i++) begin
         pulse(1'b1, 1'b0);
         if (i != 9) cyc(1);
      end
      cyc(2);
      check("lat_before", 32'(digits), 32'h0009);
      cyc(1);
      check("ten_incs", 32'(digits), 32'h0010);
      check("ten_zero", 32'(zero), 32'h0);

      // Full ripple carry without overflow.
      do_load(16'h0999);
      check("load_0999", 32'(digits), 32'h0999);
      pulse(1'b1, 1'b0);
      cyc(3);
      check("ripple_up", 32'(digits), 32'h1000);
      check("ripple_ovf", 32'(overflow), 32'h0);

      // Increment at all nines.
      do_load(16'h9999);
      pulse(1'b1, 1'b0);
      cyc(3);
`ifdef BCD_CNT_SATURATE_EN
      check("sat_digits", 32'(digits), 32'h9999);
      check("sat_ovf", 32'(overflow), 32'h1);
      cyc(1);
      check("sat_ovf_sticky", 32'(overflow), 32'h1);
`else
      check("wrap_digits", 32'(digits), 32'h0000);
      check("wrap_ovf", 32'(overflow), 32'h1);
      check("wrap_zero", 32'(zero), 32'h1);
      cyc(1);
      check("wrap_ovf_pulse", 32'(overflow), 32'h0);
`endif
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      check("clear_digits", 32'(digits), 32'h0000);
      check("clear_ovf", 32'(overflow), 32'h0);

      // Decrement from zero wraps to all nines.
      pulse(1'b0, 1'b1);
      cyc(3);
      check("unf_digits", 32'(digits), 32'h9999);
      check("unf_flag", 32'(underflow), 32'h1);
      cyc(1);
      check("unf_pulse", 32'(underflow), 32'h0);
      do_load(16'h1000);
      pulse(1'b0, 1'b1);
      cyc(3);
      check("ripple_down", 32'(digits), 32'h0999);

      // Clamp, cancelling events, clear beats load.
      do_load(16'h12F4);
      check("clamp", 32'(digits), 32'h1294);
      pulse(1'b1, 1'b1);
      cyc(3);
      check("both_digits", 32'(digits), 32'h1294);
      check("both_ovf", 32'(overflow), 32'h0);
      check("both_unf", 32'(underflow), 32'h0);
      clear    = 1'b1;
      load     = 1'b1;
      load_val = 16'h5555;
      cyc(1);
      clear    = 1'b0;
      load     = 1'b0;
      check("clr_ld_digits", 32'(digits), 32'h0000);
      check("clr_ld_zero", 32'(zero), 32'h1);

      // Reset while an increment is inside the synchronizer.
      do_load(16'h0042);
      inc = 1'b1;
      cyc(1);
      reset = 1'b1;
      #1;
      check("async_rst_digits", 32'(digits), 32'h0000);
      check("async_rst_zero", 32'(zero), 32'h1);
      inc = 1'b0;
      cyc(2);
      reset = 1'b0;
      cyc(5);
      check("no_ghost", 32'(digits), 32'h0000);
      pulse(1'b1, 1'b0);
      cyc(3);
      check("post_rst_inc", 32'(digits), 32'h0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
